key_debounce_repeat: RTL

- Per-key conditioning stage placed directly upstream of DigitalClock_Logic. Takes raw active-low push-button inputs (key1_N, key2_N, remin, rehour) and synchronises, debounces and edge-detects each one.
- Emits one-cycle press pulses, including auto-repeat pulses on long hold, plus release pulses and debounced levels, so the logic block can count set/adjust events directly.
- Clocked by the 1 kHz clock from ClockDivider, so all time constants are in clk cycles (1 cycle = 1 ms).

---
 rtl/key_debounce_repeat_if.sv | 27 ++
 rtl/key_debounce_repeat.sv | 128 ++++++++++++
 2 files changed

// File: rtl/key_debounce_repeat_if.sv
// Key channel bundle: raw active-low pins in, conditioned levels and pulses out.
// The conditioning stage takes the slave modport; the key source or bench takes the master modport.
interface key_debounce_repeat_if #(
   parameter int N_KEYS = 4
);
   logic [N_KEYS-1:0] key_N;
   logic [N_KEYS-1:0] key_level;
   logic [N_KEYS-1:0] key_press;
   logic [N_KEYS-1:0] key_release;
   logic [N_KEYS-1:0] key_long;

   modport master (
      output key_N,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_long
   );

   modport slave (
      input  key_N,
      output key_level,
      output key_press,
      output key_release,
      output key_long
   );
endinterface

// File: rtl/key_debounce_repeat.sv
// Per-key sync, debounce, long-press and auto-repeat; press pulse lands in the cycle after edge p+2+DEBOUNCE_CYC.
// Outputs are registered one-cycle pulses and levels; there is no backpressure, so the consumer must take every pulse.
module key_debounce_repeat #(
   parameter int          N_KEYS       = 4,
   parameter int          DEBOUNCE_CYC = 20,
   parameter int          LONG_CYC     = 1000,
   parameter int          REPEAT_CYC   = 200,
   parameter logic [3:0]  REPEAT_MASK  = 4'b0011,
   parameter int          CNT_W        = 10
) (
   input  logic                    clk,
   input  logic                    rst_N,
   key_debounce_repeat_if.slave    kif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DB_DN = 3'd1,
      HELD  = 3'd2,
      RPT   = 3'd3,
      DB_UP = 3'd4
   } st_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [N_KEYS-1:0] sync1_q;
   logic [N_KEYS-1:0] sync2_q;
   st_t               st_q  [N_KEYS];
   logic [CNT_W-1:0]  cnt_q [N_KEYS];
   logic [N_KEYS-1:0] level_q;
   logic [N_KEYS-1:0] press_q;
   logic [N_KEYS-1:0] release_q;
   logic [N_KEYS-1:0] long_q;

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= kif.key_N;
         sync2_q   <= sync1_q;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            case (st_q[i])
               IDLE: begin
                  if (!sync2_q[i]) begin
                     st_q[i]  <= DB_DN;
                     cnt_q[i] <= '0;
                  end
               end
               DB_DN: begin
                  if (sync2_q[i]) begin
                     st_q[i] <= IDLE;
                  end else if (cnt_q[i] == DB_LAST) begin
                     st_q[i]    <= HELD;
                     cnt_q[i]   <= '0;
                     press_q[i] <= 1'b1;
                     level_q[i] <= 1'b1;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_ONE;
                  end
               end
               HELD: begin
                  if (sync2_q[i]) begin
                     st_q[i]  <= DB_UP;
                     cnt_q[i] <= '0;
                  end else if (cnt_q[i] == LONG_LAST) begin
                     st_q[i]    <= RPT;
                     cnt_q[i]   <= '0;
                     long_q[i]  <= 1'b1;
                     press_q[i] <= REPEAT_MASK[i];
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_ONE;
                  end
               end
               RPT: begin
                  if (sync2_q[i]) begin
                     st_q[i]  <= DB_UP;
                     cnt_q[i] <= '0;
                  end else if (cnt_q[i] == RPT_LAST) begin
                     cnt_q[i]   <= '0;
                     press_q[i] <= REPEAT_MASK[i];
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_ONE;
                  end
               end
               DB_UP: begin
                  // A bounce during release goes back to HELD and restarts long/repeat timing.
                  if (!sync2_q[i]) begin
                     st_q[i]  <= HELD;
                     cnt_q[i] <= '0;
                  end else if (cnt_q[i] == DB_LAST) begin
                     st_q[i]      <= IDLE;
                     cnt_q[i]     <= '0;
                     release_q[i] <= 1'b1;
                     level_q[i]   <= 1'b0;
                     long_q[i]    <= 1'b0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + CNT_ONE;
                  end
               end
               default: begin
                  st_q[i]  <= IDLE;
                  cnt_q[i] <= '0;
               end
            endcase
         end
      end
   end

   assign kif.key_level   = level_q;
   assign kif.key_press   = press_q;
   assign kif.key_release = release_q;
   assign kif.key_long    = long_q;

endmodule
